// File: rtl/mul_seq.sv
// mul_seq: sequential 16x16 -> 16 shift-and-add multiplier that borrows a
// shared ALU for its additions.
//
// Ports
//   clk        system clock, rising edge active
//   rst        asynchronous active-high reset
//   start      multiply request, sampled only while idle
//   op_a       multiplicand, captured when start is accepted
//   op_b       multiplier, captured when start is accepted
//   busy       high whenever the block is not idle
//   done       one-cycle pulse, product is valid
//   product    low 16 bits of op_a*op_b, held until the next result
//   alu_own    high while this block drives the shared ALU inputs
//   ALUFunc    ALU function code (always ADD)
//   alu_a      ALU operand a (accumulator), zero when not owning the ALU
//   alu_b      ALU operand b (shifted multiplicand), zero when not owning
//   ALUResult  combinational result returned by the shared ALU
module mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_own,
  output logic [1:0]  ALUFunc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] ALUResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] acc_q;
  logic [15:0] mcand_q;
  logic [15:0] mplier_q;
  logic [3:0]  count_q;
  logic [15:0] product_q;
  logic        busy_q;
  logic        done_q;
  logic        alu_own_q;
  logic [15:0] acc_d;

  // Partial-product accumulate: the ALU sum is taken only when the current
  // multiplier bit is set. Consumed only in RUN, so ALUResult is ignored
  // in every other state.
  assign acc_d = mplier_q[0] ? ALUResult : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_own_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q     <= '0;
            mcand_q   <= op_a;
            mplier_q  <= op_b;
            count_q   <= '0;
            busy_q    <= 1'b1;
            alu_own_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 4'd1;
          // Always a full 16 iterations, even when the remaining multiplier
          // bits are zero, so latency is fixed.
          if (count_q == 4'd15) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            alu_own_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          alu_own_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_own = alu_own_q;
  assign ALUFunc = 2'b00;
  assign alu_a   = alu_own_q ? acc_q   : 16'h0000;
  assign alu_b   = alu_own_q ? mcand_q : 16'h0000;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq. Provides a behavioural model
// of the shared ALU and compares the DUT against plain modulo-2^16
// multiplication plus the expected cycle-level handshake timing.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_own;
  logic [1:0]  ALUFunc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] ALUResult;

  int n_cmp;
  int n_err;
  logic [15:0] held;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .alu_own   (alu_own),
    .ALUFunc   (ALUFunc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .ALUResult (ALUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU
  always_comb begin
    ALUResult = 16'h0000;
    case (ALUFunc)
      2'b00: ALUResult = alu_a + alu_b;
      2'b01: ALUResult = alu_a - alu_b;
      2'b10: ALUResult = alu_a & alu_b;
      default: ALUResult = ~alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  // One complete multiply; optional re-pulse of start with other operands
  // during RUN cycle 'intr' (0 = none).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int intr);
    logic [15:0] want;
    want  = ref_mul(a, b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == intr) begin
        start = 1'b1;
        op_a  = 16'd2;
        op_b  = 16'd2;
      end else if (c == intr + 1) begin
        start = 1'b0;
      end
      check("busy_run", busy, 1);
      check("done_timing", done, c == 17);
      check("alu_own_timing", alu_own, c <= 16);
      check("alu_func", ALUFunc, 0);
      if (c == 1) begin
        check("alu_a_first", alu_a, 0);
        check("alu_b_first", alu_b, a);
      end
      if (c == 17) begin
        check("product", product, want);
        check("alu_a_done", alu_a, 0);
        check("alu_b_done", alu_b, 0);
      end else begin
        check("product_hold", product, held);
      end
      step();
    end
    start = 1'b0;
    held  = want;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("product_after", product, held);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step();
    check("drain_busy", busy, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    held  = 16'h0000;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_alu_own", alu_own, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("idle_no_start", busy, 0);

    // Directed multiplies
    run_op(16'd3, 16'd5, 0);
    check("p_3x5", product, 16'h000F);
    run_op(16'hFFFF, 16'hFFFF, 0);
    check("p_ffff_sq", product, 16'h0001);
    run_op(16'h0100, 16'h0100, 0);
    check("p_overflow", product, 16'h0000);
    run_op(16'd7, 16'd9, 5);
    check("p_ignored_restart", product, 16'h003F);
    run_op(16'hABCD, 16'h0000, 0);
    check("p_zero_mplier", product, 16'h0000);

    // start held high: back-to-back operations every 18 cycles
    start = 1'b1;
    op_a  = 16'd4;
    op_b  = 16'd4;
    step();
    for (int c = 1; c <= 54; c++) begin
      check("held_done", done, (c % 18) == 17);
      check("held_busy", busy, (c % 18) != 0);
      if ((c % 18) == 17) check("held_product", product, 16'h0010);
      step();
    end
    start = 1'b0;
    drain();
    held = 16'h0010;
    check("held_final", product, held);

    // Reset abort in RUN cycle 8
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h0002;
    step();
    start = 1'b0;
    repeat (7) step();
    check("abort_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_alu_own", alu_own, 0);
    check("abort_alu_a", alu_a, 0);
    check("abort_alu_b", alu_b, 0);
    check("abort_product", product, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("abort_no_done", done, 0);
      step();
    end
    held = 16'h0000;
    check("abort_product_after", product, 0);

    // Reset has priority over start
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 16'd6;
    op_b  = 16'd7;
    step();
    step();
    check("rst_wins", busy, 0);
    rst = 1'b0;
    step();
    check("start_after_rst", busy, 1);
    start = 1'b0;
    drain();
    held = 16'd42;
    check("p_6x7", product, held);

    // Random operands against the arithmetic model
    for (int k = 0; k < 10; k++) begin
      run_op(16'($urandom), 16'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-high reset `rst`; all state SHALL update on the rising edge of `clk`.
REQ-002 Port `clk`: input, 1 bit, system clock.
REQ-003 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, multiply request; sampled only in IDLE.
REQ-005 Port `op_a`: input, 16 bits, multiplicand; captured when `start` is accepted.
REQ-006 Port `op_b`: input, 16 bits, multiplier; captured when `start` is accepted.
REQ-007 Port `busy`: output, 1 bit, high whenever state is not IDLE.
REQ-008 Port `done`: output, 1 bit, one-cycle pulse marking that `product` is valid.
REQ-009 Port `product`: output, 16 bits, low 16 bits of `op_a*op_b`.
REQ-010 Port `alu_own`: output, 1 bit, high while this block drives the shared ALU; the datapath ALU-input mux selects `alu_a`, `alu_b` and `ALUFunc` from this block when this is high.
REQ-011 Port `ALUFunc`: output, 2 bits, ALU function code (00 ADD, 01 SUB, 10 AND, 11 NOT).
REQ-012 Port `alu_a`: output, 16 bits, ALU operand a.
REQ-013 Port `alu_b`: output, 16 bits, ALU operand b.
REQ-014 Port `ALUResult`: input, 16 bits, combinational result from the shared ALU.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with `start`=1 at a clock edge, the block SHALL perform all of the following at that edge:
- load `acc`=0, `mcand`=`op_a`, `mplier`=`op_b`, `count`=0;
- enter RUN.
REQ-017 In IDLE with `start`=0, the block SHALL remain in IDLE.
REQ-018 In RUN, the block SHALL drive `alu_own`=1, `ALUFunc`=00 (ADD), `alu_a`=`acc` and `alu_b`=`mcand`.
REQ-019 At each RUN edge, the block SHALL perform all of the following:
- if `mplier[0]`=1, then `acc` <= `ALUResult`; otherwise `acc` is unchanged;
- `mcand` <= `mcand` shifted left by 1, zero-filled;
- `mplier` <= `mplier` shifted right by 1, zero-filled;
- `count` <= `count`+1.
REQ-020 RUN SHALL last exactly 16 cycles (`count` 0..15), with no early termination; at the edge where `count`=15, the next state SHALL be DONE.
REQ-021 On entering DONE, `product` SHALL be loaded with the final `acc` value.
REQ-022 In DONE, `done` SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-023 Latency: `done` SHALL be high in the 17th cycle after the edge that accepted `start`.
REQ-024 `product` SHALL hold its value until the next accepted `start` completes; it SHALL NOT be cleared by accepting a new `start`.
REQ-025 Arithmetic SHALL be modulo 2^16; bits of the true product above bit 15 SHALL be discarded silently, with no overflow flag; the result is identical for signed and unsigned two's-complement operands.
REQ-026 `start` SHALL be ignored in RUN and DONE, with no queuing; a `start` held high through DONE SHALL be accepted at the first IDLE edge.
REQ-027 Outside RUN, the block SHALL drive `alu_own`=0, `ALUFunc`=00, `alu_a`=0 and `alu_b`=0.
REQ-028 `busy` SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-029 The block SHALL use no value of `ALUResult` other than during RUN, and SHALL not use the ALU zero flag.

Reset
REQ-030 While `rst`=1, the block SHALL immediately, without waiting for a clock edge, set:
- state=IDLE;
- `acc`, `mcand`, `mplier`, `count` and `product` = 0;
- `busy`, `done` and `alu_own` = 0;
- `ALUFunc`, `alu_a` and `alu_b` = 0.
REQ-031 Assertion of `rst` during RUN or DONE SHALL abort the operation, with no `done` pulse and `product`=0.
REQ-032 If `rst` and `start` are both high, reset SHALL win; `start` SHALL be accepted only at an edge where `rst`=0.

Verification
REQ-033 Scenario: `op_a`=3, `op_b`=5, `start` pulse -> `busy` high for 17 cycles; `done` in cycle 17; `product`=0x000F.
REQ-034 Scenario: `op_a`=0xFFFF, `op_b`=0xFFFF -> `product`=0x0001; `op_a`=0x0100, `op_b`=0x0100 -> `product`=0x0000.
REQ-035 Scenario: `start` with `op_a`=7, `op_b`=9, then `start` re-pulsed with `op_a`=2, `op_b`=2 during RUN cycle 5 -> second request ignored; `product`=0x003F.
REQ-036 Scenario: `rst` asserted at RUN cycle 8 of 0x1234*0x0002 -> outputs 0 without waiting for a clock edge; no `done` pulse; `product`=0.
REQ-037 Scenario: `start` held high continuously with `op_a`=4, `op_b`=4 -> `done` pulses every 18 cycles; `product`=0x0010 each time.
REQ-038 Scenario: `op_b`=0 with `op_a`=0xABCD -> still 16 RUN cycles; `alu_own`=1 only in RUN; `product`=0x0000.
